// File: rtl/input_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : input_ram_arbiter
//  Description : Arbitrates one single-port input RAM between an accelerator
//                read port and a host read/write port. The accelerator wins
//                ties. Tenures are capped by MAX_BURST while the other side
//                waits. Host writes are locked out while the accelerator is busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_ram_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc_req,
  input  logic [ADDR_W-1:0] acc_addr,
  output logic              acc_gnt,
  output logic              acc_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  input  logic              acc_busy,
  output logic              host_wr_blocked,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int c_cnt_w = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [c_cnt_w-1:0] c_burst_last = c_cnt_w'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOST = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [c_cnt_w-1:0] r_burst_cnt;
  logic               w_host_elig;
  logic               w_at_limit;
  logic               w_acc_gnt;
  logic               w_host_gnt;
  logic               r_acc_rvalid;
  logic               r_host_rvalid;

  // A host write is only eligible while the accelerator is not computing.
  assign w_host_elig = host_req & ~(host_we & acc_busy);
  assign w_at_limit  = (r_burst_cnt == c_burst_last);

  // Next-state and grant decode; grants depend on current state and request only.
  always_comb begin
    w_next     = r_state;
    w_acc_gnt  = 1'b0;
    w_host_gnt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (acc_req)          w_next = ST_ACC;
        else if (w_host_elig) w_next = ST_HOST;
        else                  w_next = ST_IDLE;
      end
      ST_ACC: begin
        w_acc_gnt = acc_req;
        if (!acc_req || (w_at_limit && w_host_elig))
          w_next = w_host_elig ? ST_HOST : ST_IDLE;
      end
      ST_HOST: begin
        w_host_gnt = w_host_elig;
        if (!w_host_elig || (w_at_limit && acc_req))
          w_next = acc_req ? ST_ACC : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Grants in the current tenure; restarts on every owner change, sticks at the limit.
  always_ff @(posedge clk) begin
    if (!reset)
      r_burst_cnt <= '0;
    else if (w_next != r_state)
      r_burst_cnt <= '0;
    else if ((w_acc_gnt || w_host_gnt) && !w_at_limit)
      r_burst_cnt <= r_burst_cnt + 1'b1;
  end

  // Read-data-valid follows a read grant by one cycle; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_acc_rvalid  <= w_acc_gnt;
      r_host_rvalid <= w_host_gnt & ~host_we;
    end
  end

  assign acc_gnt         = w_acc_gnt;
  assign host_gnt        = w_host_gnt;
  assign acc_rvalid      = r_acc_rvalid;
  assign host_rvalid     = r_host_rvalid;
  assign host_wr_blocked = host_req & host_we & acc_busy;
  assign ram_en          = w_acc_gnt | w_host_gnt;
  assign ram_we          = w_host_gnt & host_we;
  assign ram_addr        = w_acc_gnt  ? acc_addr  :
                           w_host_gnt ? host_addr : '0;
  assign ram_wdata       = ram_we ? host_wdata : '0;
  assign rdata           = ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_input_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_ram_arbiter
//  Description : Self-checking bench for input_ram_arbiter: directed vector
//                table, burst/reset sequences and randomized traffic against
//                a behavioural ownership model with a RAM image.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_ram_arbiter;

  localparam int c_max = 16;

  logic       clk = 1'b0;
  logic       reset, acc_req, host_req, host_we, acc_busy;
  logic [9:0] acc_addr, host_addr;
  logic [7:0] host_wdata;
  logic       acc_gnt, acc_rvalid, host_gnt, host_rvalid, host_wr_blocked;
  logic       ram_en, ram_we;
  logic [9:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata, rdata;

  input_ram_arbiter #(.ADDR_W(10), .DATA_W(8), .MAX_BURST(c_max)) dut (
    .clk(clk), .reset(reset),
    .acc_req(acc_req), .acc_addr(acc_addr), .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .acc_busy(acc_busy), .host_wr_blocked(host_wr_blocked),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  // Environment RAM driven by the DUT's RAM port.
  logic [7:0] env_mem [0:1023];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) env_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= env_mem[ram_addr];
    end
  end

  typedef struct {
    bit rn, ar, hr, we, busy;
    logic [9:0] aa, ha;
    logic [7:0] wd;
    bit x_ag, x_hg, x_arv, x_hrv, x_blk, x_we;
    logic [9:0] x_addr;
    logic [7:0] x_rd;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  // Behavioural model: who owns the RAM, how many grants it has had, RAM image.
  int         m_owner = 0;   // 0 none, 1 accelerator, 2 host
  int         m_run   = 0;
  bit         m_arv   = 1'b0;
  bit         m_hrv   = 1'b0;
  logic [7:0] m_rd    = 8'h00;
  logic [7:0] m_mem [0:1023];

  bit s_ag, s_hg, s_arv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic vec_t mv(bit rn, bit ar, bit hr, bit we, bit busy,
                              logic [9:0] aa, logic [9:0] ha, logic [7:0] wd,
                              bit ag, bit hg, bit arv, bit hrv, bit blk, bit xwe,
                              logic [9:0] xa, logic [7:0] xrd);
    vec_t v;
    v.rn = rn; v.ar = ar; v.hr = hr; v.we = we; v.busy = busy;
    v.aa = aa; v.ha = ha; v.wd = wd;
    v.x_ag = ag; v.x_hg = hg; v.x_arv = arv; v.x_hrv = hrv; v.x_blk = blk; v.x_we = xwe;
    v.x_addr = xa; v.x_rd = xrd;
    return v;
  endfunction

  // One clock cycle: drive, check at negedge against the model (and table), advance model.
  task automatic run_cycle(input vec_t v, input bit use_x);
    bit elig, e_ag, e_hg, e_we, e_blk, lim, granted;
    int nxt;
    logic [9:0] e_addr;
    logic [7:0] e_wd;
    reset = v.rn; acc_req = v.ar; host_req = v.hr; host_we = v.we; acc_busy = v.busy;
    acc_addr = v.aa; host_addr = v.ha; host_wdata = v.wd;
    @(negedge clk);
    elig   = v.hr && !(v.we && v.busy);
    e_ag   = (m_owner == 1) && v.ar;
    e_hg   = (m_owner == 2) && elig;
    e_we   = e_hg && v.we;
    e_blk  = v.hr && v.we && v.busy;
    e_addr = e_ag ? v.aa : (e_hg ? v.ha : 10'h000);
    e_wd   = e_we ? v.wd : 8'h00;
    chk("acc_gnt", acc_gnt, e_ag);
    chk("host_gnt", host_gnt, e_hg);
    chk("ram_en", ram_en, e_ag | e_hg);
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_wdata", ram_wdata, e_wd);
    chk("host_wr_blocked", host_wr_blocked, e_blk);
    chk("acc_rvalid", acc_rvalid, m_arv);
    chk("host_rvalid", host_rvalid, m_hrv);
    if (m_arv || m_hrv) chk("rdata", rdata, m_rd);
    if (use_x) begin
      chk("tbl_acc_gnt", acc_gnt, v.x_ag);
      chk("tbl_host_gnt", host_gnt, v.x_hg);
      chk("tbl_acc_rvalid", acc_rvalid, v.x_arv);
      chk("tbl_host_rvalid", host_rvalid, v.x_hrv);
      chk("tbl_wr_blocked", host_wr_blocked, v.x_blk);
      chk("tbl_ram_we", ram_we, v.x_we);
      chk("tbl_ram_addr", ram_addr, v.x_addr);
      if (v.x_arv || v.x_hrv) chk("tbl_rdata", rdata, v.x_rd);
    end
    s_ag = acc_gnt; s_hg = host_gnt; s_arv = acc_rvalid;
    @(posedge clk);
    granted = e_ag || e_hg;
    if (granted && !e_we) m_rd = m_mem[e_addr];
    if (e_we) m_mem[v.ha] = v.wd;
    if (!v.rn) begin
      m_owner = 0; m_run = 0; m_arv = 1'b0; m_hrv = 1'b0;
    end else begin
      lim = (m_run >= c_max - 1);
      if (m_owner == 0)      nxt = v.ar ? 1 : (elig ? 2 : 0);
      else if (m_owner == 1) nxt = (!v.ar || (lim && elig)) ? (elig ? 2 : 0) : 1;
      else                   nxt = (!elig || (lim && v.ar)) ? (v.ar ? 1 : 0) : 2;
      if (nxt != m_owner)  m_run = 0;
      else if (granted)    m_run = (m_run + 1 > c_max - 1) ? c_max - 1 : m_run + 1;
      m_owner = nxt;
      m_arv = e_ag;
      m_hrv = e_hg && !v.we;
    end
    #1;
  endtask

  vec_t tbl [12];
  vec_t v;
  bit   ag_hist [40];
  bit   hg_hist [40];

  initial begin
    int first, alen, hlen, p_ar, p_hr;
    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = 8'(i) ^ 8'h5A;
      m_mem[i]   = 8'(i) ^ 8'h5A;
    end
    env_mem[10'h3FF] = 8'hA5;
    m_mem[10'h3FF]   = 8'hA5;
    ram_rdata = 8'h00;
    reset = 1'b0; acc_req = 1'b0; host_req = 1'b0; host_we = 1'b0; acc_busy = 1'b0;
    acc_addr = '0; host_addr = '0; host_wdata = '0;
    repeat (2) @(posedge clk);
    #1;

    //             rn    ar    hr    we    busy  aa      ha       wd     ag    hg    arv   hrv   blk   we    addr     rd
    tbl[0]  = mv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h12, 10'h3FF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
    tbl[1]  = mv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h12, 10'h3FF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
    tbl[2]  = mv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h12, 10'h3FF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h012, 8'h00);
    tbl[3]  = mv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h12, 10'h3FF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 8'h48);
    tbl[4]  = mv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h12, 10'h3FF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3FF, 8'h00);
    tbl[5]  = mv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h12, 10'h3FF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'hA5);
    tbl[6]  = mv(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'h00, 10'h005, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 8'h00);
    tbl[7]  = mv(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'h00, 10'h005, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 8'h00);
    tbl[8]  = mv(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h00, 10'h005, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
    tbl[9]  = mv(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h00, 10'h005, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h005, 8'h00);
    tbl[10] = mv(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'h00, 10'h005, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 8'h00);
    tbl[11] = mv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h00, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
    for (int i = 0; i < 12; i++) run_cycle(tbl[i], 1'b1);

    // Burst limit: both sides request continuously from idle.
    v = mv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h020, 10'h040, 8'h00,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
    for (int i = 0; i < 40; i++) begin
      run_cycle(v, 1'b0);
      ag_hist[i] = s_ag;
      hg_hist[i] = s_hg;
    end
    first = -1; alen = 0; hlen = 0;
    for (int i = 0; i < 40; i++) if (ag_hist[i] && first < 0) first = i;
    if (first >= 0) while (first + alen < 40 && ag_hist[first + alen]) alen++;
    if (first >= 0) while (first + alen + hlen < 40 && hg_hist[first + alen + hlen]) hlen++;
    chk("burst_first_acc_cycle", first, 1);
    chk("burst_acc_len", alen, c_max);
    chk("burst_host_len", hlen, c_max);
    chk("burst_back_to_acc", (first >= 0 && first + alen + hlen < 40) ? ag_hist[first + alen + hlen] : 1'b0, 1);

    // Reset in the cycle after an accelerator grant.
    v = mv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h077, 10'h000, 8'h00,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
    run_cycle(v, 1'b0);
    v.rn = 1'b1; v.ar = 1'b1;
    run_cycle(v, 1'b0);
    run_cycle(v, 1'b0);
    chk("rst_pre_acc_gnt", s_ag, 1);
    v.rn = 1'b0;
    run_cycle(v, 1'b0);
    chk("rst_cycle_acc_rvalid", s_arv, 1);
    run_cycle(v, 1'b0);
    chk("rst_after_acc_rvalid", s_arv, 0);
    chk("rst_after_acc_gnt", s_ag, 0);
    v.rn = 1'b1;
    run_cycle(v, 1'b0);
    chk("rst_release_no_gnt", s_ag, 0);
    chk("rst_release_no_rvalid", s_arv, 0);
    run_cycle(v, 1'b0);
    chk("rst_new_gnt", s_ag, 1);

    // Randomized traffic in segments with different request densities.
    for (int seg = 0; seg < 6; seg++) begin
      p_ar = (seg % 3 == 0) ? 90 : ((seg % 3 == 1) ? 50 : 20);
      p_hr = (seg < 3) ? 85 : 45;
      for (int i = 0; i < 500; i++) begin
        v.rn   = ($urandom_range(0, 99) != 0);
        v.ar   = ($urandom_range(0, 99) < p_ar);
        v.hr   = ($urandom_range(0, 99) < p_hr);
        v.we   = ($urandom_range(0, 99) < 40);
        v.busy = ($urandom_range(0, 99) < 25);
        v.aa   = 10'($urandom);
        v.ha   = 10'($urandom);
        v.wd   = 8'($urandom);
        run_cycle(v, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/input_ram_arbiter.md
INPUT_RAM_ARBITER -- requirements
Module: input_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 Parameter MAX_BURST, default 16, maximum consecutive grants to one owner while the other requester waits.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 acc_req / acc_addr  input  1 / ADDR_W  accelerator read request and address.
REQ-007 acc_gnt / acc_rvalid  output  1 / 1  accelerator grant; read-data-valid.
REQ-008 host_req / host_we  input  1 / 1  host request; 1 = write, 0 = read.
REQ-009 host_addr / host_wdata  input  ADDR_W / DATA_W  host address and write data.
REQ-010 host_gnt / host_rvalid  output  1 / 1  host grant; read-data-valid.
REQ-011 acc_busy  input  1  accelerator computation active; while high, host writes are locked out.
REQ-012 host_wr_blocked  output  1  pulse: host write pending but locked this cycle.
REQ-013 ram_en / ram_we  output  1 / 1  RAM port enable and write enable.
REQ-014 ram_addr / ram_wdata  output  ADDR_W / DATA_W  RAM address and write data.
REQ-015 ram_rdata  input  DATA_W  RAM read data, valid 1 cycle after a read enable.
REQ-016 rdata  output  DATA_W  ram_rdata passed through combinationally to both requesters.

Function
REQ-017 Host eligibility: host_elig = host_req & ~(host_we & acc_busy).
REQ-018 FSM states: IDLE, ACC, HOST; registered.
REQ-019 IDLE: no grant; next = ACC if acc_req, else HOST if host_elig, else IDLE (accelerator has priority on simultaneous requests).
REQ-020 ACC: acc_gnt = acc_req; host_gnt = 0.
REQ-021 ACC exit: if ~acc_req, or (burst_cnt == MAX_BURST-1 & host_elig), next = HOST if host_elig, else IDLE; otherwise stay in ACC.
REQ-022 HOST: host_gnt = host_elig; acc_gnt = 0.
REQ-023 HOST exit: if ~host_elig, or (burst_cnt == MAX_BURST-1 & acc_req), next = ACC if acc_req, else IDLE; otherwise stay in HOST.
REQ-024 Grants are combinational from the current state and request; at most one grant is high in any cycle.
REQ-025 burst_cnt: increments on each grant; clears to 0 on any state change; saturates at MAX_BURST-1.
REQ-026 ram_en = acc_gnt | host_gnt; ram_we = host_gnt & host_we.
REQ-027 ram_addr = acc_addr when acc_gnt, host_addr when host_gnt, else 0.
REQ-028 ram_wdata = host_wdata when ram_we, else 0.
REQ-029 acc_rvalid is registered acc_gnt, asserting exactly 1 cycle after the grant.
REQ-030 host_rvalid is registered (host_gnt & ~host_we); host writes produce no rvalid.
REQ-031 host_wr_blocked = host_req & host_we & acc_busy, combinational, in any state.
REQ-032 If acc_busy rises while the state is HOST with a pending write, the FSM leaves HOST in that same cycle per REQ-023; the locked write receives no grant.
REQ-033 A requester dropping req in the cycle of its burst limit exits without a lost or duplicate grant.

Reset
REQ-034 On reset low at a clock edge:
- state = IDLE; burst_cnt = 0; acc_rvalid = host_rvalid = 0.
- any read in flight is discarded, with no rvalid after reset.
REQ-035 While reset is low, grants, ram_en and ram_we are 0 in the following cycles.

Verification
REQ-036 Simultaneous request: acc_req = host_req = 1 (host read) from IDLE.
- 1 cycle later: acc_gnt = 1, host_gnt = 0.
- acc_rvalid = 1 one cycle after each acc_gnt.
REQ-037 Burst limit: acc_req held high, host read pending, MAX_BURST = 16.
- exactly 16 consecutive acc_gnt.
- then host_gnt asserts on the next cycle, with no idle gap.
REQ-038 Write lock: acc_busy = 1, host write to addr 5.
- host_gnt = 0 and host_wr_blocked = 1 every cycle.
- after acc_busy falls: IDLE -> HOST, then ram_we = 1, ram_addr = 5.
REQ-039 Host read of addr 0x3FF with ram_rdata = 0xA5.
- host_rvalid = 1 exactly 1 cycle after host_gnt.
- rdata = 0xA5 in that cycle.
REQ-040 Reset mid-operation: reset low in the cycle after acc_gnt.
- acc_rvalid = 0 at the next edge.
- state = IDLE; no grants until reset is high and a new request arrives.
